adc_bram_capture: RTL
=====================

Name: adc_bram_capture

Overview:
Capture stage between the ADC AXI-Stream output of the RF data converter and the BRAM-to-host buffer read by the processing system.
- On a software start pulse it records a programmable number of optionally decimated 64-bit ADC beats into consecutive BRAM words, then raises done.
- It never back-pressures the converter.

Parameters:
ADC_AXIS_DATAWIDTH, 64, width of the ADC stream data word
BRAMTOHOST_ADDRWIDTH, 32, BRAM byte-address width
BRAMTOHOST_DATAWIDTH, 64, BRAM data width; must equal ADC_AXIS_DATAWIDTH
DEPTH_LOG2, 12, log2 of buffer depth in words (4096)

Ports:
aclk  in  1  capture clock, same as the ADC AXIS clock
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  ADC_AXIS_DATAWIDTH  ADC sample word
s_axis_tvalid  in  1  ADC beat valid
s_axis_tready  out  1  always 1 outside reset
start  in  1  single-cycle capture request
abort  in  1  single-cycle cancel
nsamples  in  DEPTH_LOG2+1  words to capture; sampled at start
decim  in  8  keep 1 of every decim+1 valid beats; sampled at start
bram_addr  out  BRAMTOHOST_ADDRWIDTH  byte address
bram_din  out  BRAMTOHOST_DATAWIDTH  write data
bram_en  out  1  BRAM enable
bram_we  out  BRAMTOHOST_DATAWIDTH/8  byte write enables, all-ones or all-zeros
busy  out  1  capture in progress
done  out  1  capture complete; held until next start or abort
wcount  out  DEPTH_LOG2+1  words written in the current or last capture

Behaviour:
- Reset (aresetn=0, asynchronous): state IDLE; all outputs 0, including s_axis_tready. tready goes to 1 on the first aclk edge after reset release.
- States: IDLE, CAPTURE, DONE.
- IDLE, or DONE, with start=1:
  - Latch n = min(nsamples, 2^DEPTH_LOG2) and d = decim.
  - Clear wcount, the decimation counter and the word index; clear done.
  - If n=0, go directly to DONE next cycle with no writes. Otherwise go to CAPTURE and set busy.
- CAPTURE, accepted beat (tvalid=1):
  - If the decimation counter is 0, the beat is kept and the counter reloads d; otherwise the counter decrements.
  - The first valid beat after start is always kept.
  - A kept beat drives bram_en=1, bram_we=all-ones, bram_din=tdata and bram_addr=index*(BRAMTOHOST_DATAWIDTH/8) on the following cycle (1-cycle registered latency). index and wcount then increment.
  - Cycles with tvalid=0 produce no write and do not advance the decimation counter.
- When the kept-beat count reaches n, the last write issues, then:
  - The next cycle: busy=0, done=1, state DONE.
  - Beats arriving after the last kept beat are dropped.
- start while in CAPTURE: ignored.
- abort in any state: next cycle IDLE, busy=0, done=0. A write already registered in the pipeline still completes. wcount holds the partial count.
- start and abort in the same cycle: abort wins.
- Address never wraps. index is at most n-1 ≤ 2^DEPTH_LOG2-1, so the maximum address is (2^DEPTH_LOG2-1)*8.
- Outside write cycles: bram_en=0, bram_we=0, bram_din and bram_addr hold their last value.

Decomposition:
- Shared package adc_capture_pkg:
  - State encoding: IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2.
  - BYTES_PER_WORD = BRAMTOHOST_DATAWIDTH/8.
  - A width-check constant asserting ADC_AXIS_DATAWIDTH equals BRAMTOHOST_DATAWIDTH.
- One natural sub-module, adc_capture_decim: the 8-bit reload/decrement counter.
  - Inputs: load, d, beat.
  - Output: keep.

Test Plan:
- Reset, then start with nsamples=4, decim=0, tvalid=1 continuously, tdata=0x10,0x11,… → writes at addr 0,8,16,24 with data 0x10..0x13, each one cycle after the accepted beat; done=1 on the cycle after the last write; wcount=4.
- nsamples=3, decim=2, continuous beats 0..8 → beats 0,3,6 written to addr 0,8,16; done set; beats 7,8 not written.
- nsamples=2, decim=0, tvalid toggling 1,0,0,1 → exactly 2 writes, at the cycles following each valid beat; s_axis_tready stays 1 throughout.
- Abort after 2 of 10 writes → busy=0 and done=0 next cycle; wcount=2; no further bram_en. A second start with nsamples=1 restarts at addr 0.
- nsamples=0 → done=1 within 2 cycles with no bram_en. nsamples=8191 → clamped to 4096 writes; last addr=0x7FF8.
- aresetn asserted mid-capture → all outputs 0 immediately without a clock edge; after release, state IDLE and a new start works.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC-to-BRAM capture stage.
package adc_capture_pkg;

  localparam int DEF_ADC_DW  = 64;
  localparam int DEF_BRAM_AW = 32;
  localparam int DEF_BRAM_DW = 64;
  localparam int DEF_DEPTH_L2 = 12;

  localparam int BYTES_PER_WORD = DEF_BRAM_DW / 8;

  localparam bit WIDTHS_MATCH = (DEF_ADC_DW == DEF_BRAM_DW);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;

  function automatic bit widths_match(input int a, input int b);
    return a == b;
  endfunction

endpackage

// File: rtl/adc_capture_decim.sv
// Keep-one-of-(d+1) beat selector; the first beat after load is kept.
module adc_capture_decim
  import adc_capture_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] d,
  input  logic       beat,
  output logic       keep
);

  logic [7:0] d_q, d_d;
  logic [7:0] cnt_q, cnt_d;

  assign keep = beat && (cnt_q == 8'd0);

  always_comb begin
    d_d   = d_q;
    cnt_d = cnt_q;
    if (load) begin
      d_d   = d;
      cnt_d = 8'd0;
    end else if (beat) begin
      cnt_d = keep ? d_q : cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= 8'd0;
      cnt_q <= 8'd0;
    end else begin
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_bram_capture.sv
// Records a programmed number of decimated ADC beats into BRAM.
// Never back-pressures the converter; writes land one cycle after the beat.
module adc_bram_capture
  import adc_capture_pkg::*;
#(
  parameter int ADC_AXIS_DATAWIDTH   = DEF_ADC_DW,
  parameter int BRAMTOHOST_ADDRWIDTH = DEF_BRAM_AW,
  parameter int BRAMTOHOST_DATAWIDTH = DEF_BRAM_DW,
  parameter int DEPTH_LOG2           = DEF_DEPTH_L2
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [ADC_AXIS_DATAWIDTH-1:0]     s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              start,
  input  logic                              abort,
  input  logic [DEPTH_LOG2:0]               nsamples,
  input  logic [7:0]                        decim,
  output logic [BRAMTOHOST_ADDRWIDTH-1:0]   bram_addr,
  output logic [BRAMTOHOST_DATAWIDTH-1:0]   bram_din,
  output logic                              bram_en,
  output logic [BRAMTOHOST_DATAWIDTH/8-1:0] bram_we,
  output logic                              busy,
  output logic                              done,
  output logic [DEPTH_LOG2:0]               wcount
);

  localparam int BPW = BRAMTOHOST_DATAWIDTH / 8;
  localparam int CW  = DEPTH_LOG2 + 1;
  localparam int AW  = BRAMTOHOST_ADDRWIDTH;

  localparam logic [CW-1:0] NMAX = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0] ONE  = 1;

  if (!widths_match(ADC_AXIS_DATAWIDTH, BRAMTOHOST_DATAWIDTH)) begin : g_bad_width
    $error("ADC and BRAM data widths differ");
  end

  cap_state_e state_q, state_d;

  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] wcount_q, wcount_d;
  logic [CW-1:0] n_clamp;
  logic          tready_q;
  logic          load;
  logic          beat;
  logic          keep;

  logic                            en_q;
  logic [BPW-1:0]                  we_q;
  logic [AW-1:0]                   addr_q;
  logic [BRAMTOHOST_DATAWIDTH-1:0] din_q;

  assign n_clamp = (nsamples > NMAX) ? NMAX : nsamples;

  // Once wcount reaches n the remaining beats are dropped until DONE.
  assign beat = (state_q == ST_CAPTURE) && s_axis_tvalid && tready_q
             && (wcount_q != n_q) && !abort;

  adc_capture_decim u_decim (
    .clk   (aclk),
    .rst_n (aresetn),
    .load  (load),
    .d     (decim),
    .beat  (beat),
    .keep  (keep)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          n_d     = n_clamp;
          state_d = (n_clamp == '0) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (wcount_q == n_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      n_d     = n_q;
      load    = 1'b0;
    end
  end

  always_comb begin
    wcount_d = wcount_q;
    if (load)      wcount_d = '0;
    else if (keep) wcount_d = wcount_q + ONE;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      wcount_q <= '0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      wcount_q <= wcount_d;
      tready_q <= 1'b1;
    end
  end

  // wcount doubles as the word index of the beat being kept.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q   <= 1'b0;
      we_q   <= '0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      en_q <= keep;
      we_q <= keep ? '1 : '0;
      if (keep) begin
        addr_q <= AW'(wcount_q[DEPTH_LOG2-1:0]) * AW'(BPW);
        din_q  <= s_axis_tdata;
      end
    end
  end

  assign s_axis_tready = tready_q;
  assign bram_en       = en_q;
  assign bram_we       = we_q;
  assign bram_addr     = addr_q;
  assign bram_din      = din_q;
  assign busy          = (state_q == ST_CAPTURE);
  assign done          = (state_q == ST_DONE);
  assign wcount        = wcount_q;

endmodule
